world_select_ctrl: RTL and testbench

Parametrised world/map selector for the game display pipeline. It holds exactly one active map out of `NUM_MAPS` and drives a one-hot enable to the map ROM/tile banks. Map changes use a blanking handshake so the renderer never samples a half-switched map. It supports direct selection and next/previous cycling with wrap-around, and queues one change requested mid-transition.

---
 rtl/world_select_ctrl_if.sv | 26 ++
 rtl/world_select_ctrl.sv | 134 +++++++++++++
 tb/tb_world_select_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/world_select_ctrl_if.sv
// Map-selector bus: change requests in, active-map state and status out.
interface world_select_ctrl_if #(
  parameter int NUM_MAPS = 4,
  parameter int SEL_W    = $clog2(NUM_MAPS)
);
  logic                map_change;
  logic                direct;
  logic                dir;
  logic [SEL_W-1:0]    map_select;
  logic [NUM_MAPS-1:0] map_en;
  logic [SEL_W-1:0]    map_idx;
  logic                blank;
  logic                busy;
  logic                swap_done;
  logic                sel_err;

  modport master (
    output map_change, direct, dir, map_select,
    input  map_en, map_idx, blank, busy, swap_done, sel_err
  );

  modport slave (
    input  map_change, direct, dir, map_select,
    output map_en, map_idx, blank, busy, swap_done, sel_err
  );
endinterface

// File: rtl/world_select_ctrl.sv
// World/map selector: holds one active map, switches it behind a blanking
// window so the renderer never sees a half-switched map, and queues one
// request that arrives while a switch is already in flight.
module world_select_ctrl #(
  parameter int NUM_MAPS     = 4,
  parameter int SEL_W        = $clog2(NUM_MAPS),
  parameter int BLANK_CYCLES = 16
) (
  input logic               clk,
  input logic               reset_n,
  world_select_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BLANK, SWAP} state_t;

  localparam logic [SEL_W-1:0] LAST     = SEL_W'(NUM_MAPS - 1);
  localparam logic [7:0]       CNT_LOAD = 8'(BLANK_CYCLES - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [SEL_W-1:0]    tgt_q, tgt_d;
  logic [SEL_W-1:0]    pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [NUM_MAPS-1:0] en_q;
  logic                blank_q, busy_q, done_q, err_q, chg_q;
  logic                done_d;

  logic                req, sel_bad, req_ok, req_bad;
  logic [SEL_W-1:0]    cur, req_tgt, nxt;
  logic                nxt_v;

  // Request decode: edge detect, range check and target relative to the
  // effective current map (queued target if any, else the live map).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    req     = bus.map_change & ~chg_q;
    cur     = pend_v_q ? pend_q : idx_q;
    sel_bad = bus.direct & (int'(bus.map_select) >= NUM_MAPS);
    req_ok  = req & ~sel_bad;
    req_bad = req & sel_bad;
    req_tgt = bus.map_select;
    if (!bus.direct) begin
      if (!bus.dir) req_tgt = (cur == LAST)        ? '0   : cur + SEL_W'(1);
      else          req_tgt = (cur == SEL_W'(0))   ? LAST : cur - SEL_W'(1);
    end
  end

  // Transition FSM: next state, counter, target, pending slot and map index.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    nxt_v    = pend_v_q | req_ok;
    nxt      = req_ok ? req_tgt : pend_q;
    unique case (state_q)
      IDLE: begin
        if (req_ok && req_tgt != idx_q) begin
          tgt_d   = req_tgt;
          cnt_d   = CNT_LOAD;
          state_d = BLANK;
        end
      end
      BLANK: begin
        if (req_ok) begin
          pend_d   = req_tgt;
          pend_v_d = 1'b1;
        end
        if (cnt_q == 8'd0) state_d = SWAP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      SWAP: begin
        // A request landing in this very cycle is newer than the queued one.
        idx_d    = tgt_q;
        done_d   = 1'b1;
        pend_v_d = 1'b0;
        if (nxt_v && nxt != tgt_q) begin
          tgt_d   = nxt;
          cnt_d   = CNT_LOAD;
          state_d = BLANK;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transition and drops
  // the queued request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tgt_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      idx_q    <= '0;
      en_q     <= NUM_MAPS'(1);
      blank_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      idx_q    <= idx_d;
      en_q     <= NUM_MAPS'(1) << idx_d;
      blank_q  <= (state_d != IDLE);
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
      err_q    <= req_bad;
      chg_q    <= bus.map_change;
    end
  end

  assign bus.map_en    = en_q;
  assign bus.map_idx   = idx_q;
  assign bus.blank     = blank_q;
  assign bus.busy      = busy_q;
  assign bus.swap_done = done_q;
  assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_world_select_ctrl.sv
// Bench for world_select_ctrl: directed table and corner sequences on a
// 4-map/16-cycle instance, range checks and a randomized run against a
// time-based reference model on a 5-map/3-cycle instance.
module tb_world_select_ctrl;
  localparam int B4 = 16;
  localparam int B5 = 3;
  localparam int N5 = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  world_select_ctrl_if #(.NUM_MAPS(4)) bus4 ();
  world_select_ctrl_if #(.NUM_MAPS(N5)) bus5 ();

  world_select_ctrl #(.NUM_MAPS(4), .BLANK_CYCLES(B4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4.slave));
  world_select_ctrl #(.NUM_MAPS(N5), .BLANK_CYCLES(B5)) dut5 (
    .clk(clk), .reset_n(reset_n), .bus(bus5.slave));

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Passive monitors: running event counts plus map_en invariants.
  int   blank4 = 0, done4 = 0, rise4 = 0, viol4 = 0;
  int   busy5 = 0, done5 = 0, err5 = 0;
  logic prev_blank4 = 1'b0;
  logic [3:0] prev_en4 = 4'b0001;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_blank4 = 1'b0;
      prev_en4    = bus4.map_en;
    end else begin
      if (bus4.blank) blank4++;
      if (bus4.swap_done) done4++;
      if (bus4.blank && !prev_blank4) rise4++;
      if (bus4.map_en != (4'b0001 << bus4.map_idx)) viol4++;
      if (bus4.map_en != prev_en4 && !bus4.swap_done) viol4++;
      prev_blank4 = bus4.blank;
      prev_en4    = bus4.map_en;
      if (bus5.busy) busy5++;
      if (bus5.swap_done) done5++;
      if (bus5.sel_err) err5++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic req4(input bit d, input bit dr, input logic [1:0] s, input int hold);
    bus4.direct = d; bus4.dir = dr; bus4.map_select = s; bus4.map_change = 1'b1;
    wait_cycles(hold);
    bus4.map_change = 1'b0;
  endtask

  task automatic req5(input bit d, input bit dr, input logic [2:0] s);
    bus5.direct = d; bus5.dir = dr; bus5.map_select = s; bus5.map_change = 1'b1;
    wait_cycles(1);
    bus5.map_change = 1'b0;
  endtask

  // Reference model for the 5-map instance, expressed in absolute edge
  // numbers: a transition started at edge T swaps at edge T+B5+1.
  int  m_idx, m_tgt, m_swap, n_edge;
  bit  m_act, m_prev_mc, e_done, e_err;
  int  m_pend[$];

  task automatic model_step(input bit mc, input bit d, input bit dr, input int s);
    int cur, t;
    n_edge++;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (mc && !m_prev_mc) begin
      cur = (m_pend.size() > 0) ? m_pend[0] : m_idx;
      if (d && s >= N5) e_err = 1'b1;
      else begin
        if (d)        t = s;
        else if (!dr) t = (cur + 1) % N5;
        else          t = (cur + N5 - 1) % N5;
        if (!m_act) begin
          if (t != m_idx) begin
            m_act = 1'b1; m_tgt = t; m_swap = n_edge + B5 + 1;
          end
        end else begin
          m_pend.delete();
          m_pend.push_back(t);
        end
      end
    end
    m_prev_mc = mc;
    if (m_act && n_edge == m_swap) begin
      m_idx  = m_tgt;
      e_done = 1'b1;
      if (m_pend.size() > 0) begin
        t = m_pend.pop_front();
        if (t != m_idx) begin
          m_tgt = t; m_swap = n_edge + B5 + 1;
        end else m_act = 1'b0;
      end else m_act = 1'b0;
    end
  endtask

  typedef struct {
    bit         direct;
    bit         dir;
    logic [1:0] sel;
    int         exp_idx;
    int         exp_swaps;
    int         exp_blank;
  } vec4_t;

  vec4_t tbl[8];

  initial begin
    int s_b, s_d, s_r, s_e, s_busy;
    bit mc, d, dr;
    int s;
    logic [11:0] got, exp;

    tbl[0] = '{0, 0, 2'd0, 3, 1, B4 + 1};  // next 2 -> 3
    tbl[1] = '{0, 0, 2'd0, 0, 1, B4 + 1};  // next wraps 3 -> 0
    tbl[2] = '{0, 1, 2'd0, 3, 1, B4 + 1};  // previous wraps 0 -> 3
    tbl[3] = '{1, 0, 2'd3, 3, 0, 0};       // direct to current map: no-op
    tbl[4] = '{0, 1, 2'd0, 2, 1, B4 + 1};  // previous 3 -> 2
    tbl[5] = '{1, 0, 2'd0, 0, 1, B4 + 1};  // direct 0
    tbl[6] = '{0, 1, 2'd0, 3, 1, B4 + 1};  // previous wraps 0 -> 3
    tbl[7] = '{1, 0, 2'd1, 1, 1, B4 + 1};  // direct 1

    reset_n = 1'b0;
    bus4.map_change = 0; bus4.direct = 0; bus4.dir = 0; bus4.map_select = '0;
    bus5.map_change = 0; bus5.direct = 0; bus5.dir = 0; bus5.map_select = '0;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(2);

    // Reset state
    check("rst_idx", bus4.map_idx, 0);
    check("rst_en", bus4.map_en, 4'b0001);
    check("rst_flags", {bus4.blank, bus4.busy, bus4.swap_done, bus4.sel_err}, 4'b0000);

    // Direct select 2 with exact latency
    s_b = blank4; s_d = done4;
    req4(1'b1, 1'b0, 2'd2, 1);
    check("lat_busy_t1", {bus4.busy, bus4.blank}, 2'b11);
    wait_cycles(B4);
    check("lat_last_blank", {bus4.blank, bus4.swap_done, bus4.map_en}, {2'b10, 4'b0001});
    wait_cycles(1);
    check("lat_swap", {bus4.blank, bus4.busy, bus4.swap_done, bus4.map_en}, {3'b001, 4'b0100});
    check("lat_idx", bus4.map_idx, 2);
    wait_cycles(1);
    check("lat_done_pulse", bus4.swap_done, 1'b0);
    check("lat_blank_len", blank4 - s_b, B4 + 1);
    check("lat_swaps", done4 - s_d, 1);

    // Table of single requests
    for (int i = 0; i < 8; i++) begin
      s_b = blank4; s_d = done4;
      req4(tbl[i].direct, tbl[i].dir, tbl[i].sel, 1);
      wait_cycles(B4 + 4);
      check($sformatf("tbl%0d_idx", i), bus4.map_idx, tbl[i].exp_idx);
      check($sformatf("tbl%0d_en", i), bus4.map_en, 4'b0001 << tbl[i].exp_idx);
      check($sformatf("tbl%0d_swaps", i), done4 - s_d, tbl[i].exp_swaps);
      check($sformatf("tbl%0d_blank", i), blank4 - s_b, tbl[i].exp_blank);
    end

    // Holding map_change high gives one transition (1 -> 2)
    s_b = blank4; s_d = done4;
    req4(1'b0, 1'b0, 2'd0, 40);
    wait_cycles(5);
    check("hold_swaps", done4 - s_d, 1);
    check("hold_blank", blank4 - s_b, B4 + 1);
    check("hold_idx", bus4.map_idx, 2);

    // Queued requests: toward 1, then next, then direct 3 during BLANK
    reset_n = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(1);
    check("q_rst_idx", bus4.map_idx, 0);
    s_b = blank4; s_d = done4; s_r = rise4;
    req4(1'b1, 1'b0, 2'd1, 1);
    wait_cycles(3);
    req4(1'b0, 1'b0, 2'd0, 1);
    wait_cycles(2);
    req4(1'b1, 1'b0, 2'd3, 1);
    wait_cycles(2 * B4 + 10);
    check("q_idx", bus4.map_idx, 3);
    check("q_en", bus4.map_en, 4'b1000);
    check("q_swaps", done4 - s_d, 2);
    check("q_blank_rises", rise4 - s_r, 1);
    check("q_blank_len", blank4 - s_b, 2 * (B4 + 1));

    // Reset in the fifth BLANK cycle aborts the switch
    req4(1'b1, 1'b0, 2'd2, 1);
    wait_cycles(4);
    check("abort_in_blank", bus4.blank, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_now", {bus4.blank, bus4.busy, bus4.map_en}, {2'b00, 4'b0001});
    wait_cycles(2);
    reset_n = 1'b1;
    s_d = done4;
    wait_cycles(30);
    check("abort_no_swap", done4 - s_d, 0);
    check("abort_idx", bus4.map_idx, 0);

    // map_change already high at reset release counts as an edge
    reset_n = 1'b0;
    bus4.direct = 1'b1; bus4.map_select = 2'd1; bus4.map_change = 1'b1;
    wait_cycles(1);
    reset_n = 1'b1;
    wait_cycles(1);
    check("rel_edge_busy", bus4.busy, 1'b1);
    bus4.map_change = 1'b0;
    wait_cycles(B4 + 3);
    check("rel_edge_idx", bus4.map_idx, 1);
    check("invariants4", viol4, 0);

    // Out-of-range direct selects on the 5-map instance
    s_e = err5; s_busy = busy5; s_d = done5;
    req5(1'b1, 1'b0, 3'd6);
    check("err6_pulse", bus5.sel_err, 1'b1);
    wait_cycles(1);
    check("err6_clear", bus5.sel_err, 1'b0);
    req5(1'b1, 1'b0, 3'd5);
    wait_cycles(8);
    check("err_count", err5 - s_e, 2);
    check("err_no_busy", busy5 - s_busy, 0);
    check("err_no_swap", done5 - s_d, 0);
    check("err_idx", bus5.map_idx, 0);
    req5(1'b1, 1'b0, 3'd4);
    check("sel4_no_err", bus5.sel_err, 1'b0);
    wait_cycles(B5 + 3);
    check("sel4_idx", {bus5.map_idx, bus5.map_en}, {3'd4, 5'b10000});

    // Randomized run against the reference model
    reset_n = 1'b0;
    bus5.map_change = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    m_idx = 0; m_tgt = 0; m_swap = 0; n_edge = 0;
    m_act = 1'b0; m_prev_mc = 1'b0; e_done = 1'b0; e_err = 1'b0;
    m_pend.delete();
    mc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      got = {bus5.map_en, bus5.map_idx, bus5.blank, bus5.busy, bus5.swap_done, bus5.sel_err};
      exp = {5'(5'b00001 << m_idx), 3'(m_idx), m_act, m_act, e_done, e_err};
      check($sformatf("rand%0d", i), 32'(got), 32'(exp));
      mc = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 1) == 1);
      dr = ($urandom_range(0, 1) == 1);
      s  = int'($urandom_range(0, 7));
      bus5.map_change = mc; bus5.direct = d; bus5.dir = dr; bus5.map_select = 3'(s);
      model_step(mc, d, dr, s);
      wait_cycles(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
